serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 122 ++++++++++++
 tb/tb_serial_adder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: a+b+cin one bit per cycle, LSB first; ovf output when SERIAL_ADDER_OVF_EN is defined.
// Latency: start accepted at edge T0, done pulses between T(WIDTH) and T(WIDTH+1).
// Backpressure: none; start is only sampled in IDLE, ignored while busy.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic             c;
    logic             s_bit;
    logic             c_nxt;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        load      = 1'b0;
        last      = (cnt == CW'(WIDTH - 1));
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One full-adder slice; the sum bit enters the result at the MSB so the
    // result is aligned once WIDTH bits have been shifted in.
    always_comb begin
        s_bit              = a_sh[0] ^ b_sh[0] ^ c;
        c_nxt              = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
        res_nxt            = res >> 1;
        res_nxt[WIDTH-1]   = s_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            res  <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf  <= 1'b0;
`endif
        end else if (load) begin
            a_sh <= a;
            b_sh <= b;
            c    <= cin;
            res  <= '0;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            c    <= c_nxt;
            res  <= res_nxt;
            cnt  <= cnt + CW'(1);
            if (last) begin
                sum  <= res_nxt;
                cout <= c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
                // c is the carry into the MSB at this point
                ovf  <= c ^ c_nxt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 and WIDTH=1 instances, directed vectors,
// expected results queued by the drivers and popped by done-triggered monitors.
module tb_serial_adder;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_fail = 0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;
    logic [7:0] prev8 = '0;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       cin1 = 1'b0;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8;
    logic       ovf1;
`endif

    exp_t q8[$];
    exp_t q1[$];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf1)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL done8_unexpected: got done=1, expected no pulse (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("sum8", 32'(sum8), 32'(e.sum));
                chk("cout8", 32'(cout8), 32'(e.cout));
                chk("done8_cycle", 32'(cyc), 32'(e.cyc));
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf8", 32'(ovf8), 32'(e.ovf));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL done1_unexpected: got done=1, expected no pulse (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("sum1", 32'(sum1), 32'(e.sum));
                chk("cout1", 32'(cout1), 32'(e.cout));
                chk("done1_cycle", 32'(cyc), 32'(e.cyc));
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf1", 32'(ovf1), 32'(e.ovf));
`endif
            end
        end
    end

    // poke: re-assert start with junk operands while the operation is running
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [7:0] esum, input logic ecout, input logic eovf,
                        input bit poke);
        @(negedge clk);
        a8 = a;
        b8 = b;
        cin8 = ci;
        start8 = 1'b1;
        q8.push_back('{esum, ecout, eovf, cyc + 1 + 8});
        @(negedge clk);
        start8 = 1'b0;
        chk("busy8_run", 32'(busy8), 32'd1);
        chk("sum8_hold", 32'(sum8), 32'(prev8));
        a8 = ~a;
        b8 = ~b;
        cin8 = ~ci;
        for (int k = 2; k <= 10; k++) begin
            @(negedge clk);
            if (poke && k == 3) begin
                start8 = 1'b1;
                a8 = 8'hFF;
                b8 = 8'hFF;
            end
            if (poke && k == 4) start8 = 1'b0;
            if (k == 9) chk("busy8_done", 32'(busy8), 32'd1);
        end
        chk("busy8_idle", 32'(busy8), 32'd0);
        chk("q8_drained", 32'(q8.size()), 32'd0);
        q8.delete();
        prev8 = esum;
    endtask

    task automatic run1(input logic [2:0] abc, input logic [1:0] exp_cs, input logic eovf);
        @(negedge clk);
        a1 = abc[2];
        b1 = abc[1];
        cin1 = abc[0];
        start1 = 1'b1;
        q1.push_back('{{7'd0, exp_cs[0]}, exp_cs[1], eovf, cyc + 2});
        @(negedge clk);
        start1 = 1'b0;
        chk("busy1_run", 32'(busy1), 32'd1);
        repeat (2) @(negedge clk);
        chk("busy1_idle", 32'(busy1), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        q1.delete();
    endtask

    // {a, b, cin, sum, cout, ovf}
    logic [26:0] vec8 [8] = '{
        {8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0},
        {8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
        {8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0},
        {8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
        {8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1},
        {8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0},
        {8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0},
        {8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0}
    };

    // {cout, sum} and ovf for {a,b,cin} = 000..111
    logic [1:0] cs1  [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    logic       ovf1e[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        #12;
        chk("rst_sum8", 32'(sum8), 32'd0);
        chk("rst_cout8", 32'(cout8), 32'd0);
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            logic [26:0] v;
            v = vec8[i];
            run8(v[26:19], v[18:11], v[10], v[9:2], v[1], v[0], 1'b0);
        end

        run8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);

        // reset in the middle of an operation with start held high
        @(negedge clk);
        a8 = 8'h55;
        b8 = 8'h22;
        cin8 = 1'b0;
        start8 = 1'b1;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sum8", 32'(sum8), 32'd0);
        chk("arst_cout8", 32'(cout8), 32'd0);
        chk("arst_busy8", 32'(busy8), 32'd0);
        chk("arst_done8", 32'(done8), 32'd0);
        repeat (2) @(negedge clk);
        chk("arst_busy8_held", 32'(busy8), 32'd0);
        rst_n = 1'b1;
        start8 = 1'b0;
        prev8 = 8'h00;
        run8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run1(3'(i), cs1[i], ovf1e[i]);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
